// File: rtl/run_dec.sv
// ============================================================================
// run_dec: JPEG-LS run-interruption sample decoder; macro RUN_DEC_CHK_EN adds sticky code checks. Rev 1.0
// ============================================================================
`default_nettype none

module run_dec #(
   parameter int LIMIT = 23
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_init,
   input  logic       i_vl,
   output logic       o_rdy,
   input  logic [7:0] i_px,
   input  logic       i_s,
   input  logic       i_q,
   input  logic [3:0] i_cn,
   output logic       o_kvl,
   output logic [3:0] o_k,
   output logic [4:0] o_lm,
   input  logic       i_bvl,
   input  logic [4:0] i_zc,
   input  logic [7:0] i_bv,
   output logic       o_vl,
   output logic [7:0] o_x,
   output logic       o_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_KCAL = 2'd1,
      S_WAIT = 2'd2,
      S_REC  = 2'd3
   } state_t;

   localparam logic [6:0]  N_INIT = 7'd1;
   localparam logic [16:0] A_INIT = 17'd4;
   localparam logic [6:0]  B_INIT = 7'd0;

   state_t      state;
   logic [7:0]  px_lat;
   logic        s_lat;
   logic        q_lat;
   logic [3:0]  cn_lat;
   logic [4:0]  zc_lat;
   logic [7:0]  bv_lat;

   logic [6:0]  n_ctx [2];
   logic [16:0] a_ctx [2];
   logic [6:0]  b_ctx [2];

   logic [6:0]  n_cur;
   logic [16:0] a_cur;
   logic [6:0]  b_cur;
   logic [18:0] at;
   logic [3:0]  k_calc;
   logic [4:0]  lm_calc;
   logic [9:0]  kmask;
   logic [9:0]  zc_sh;
   logic [9:0]  merr;
   logic        map;
   logic [9:0]  abserr;
   logic        cond;
   logic        err_neg;
   logic        err_pos;
   logic        add;
   logic [7:0]  x_calc;
   logic        halve;
   logic [6:0]  n_new;
   logic [6:0]  b_inc;
   logic [6:0]  b_new;
   logic [16:0] a_inc;
   logic [16:0] a_new;

   assign o_rdy = (state == S_IDLE);

   always_comb begin
      n_cur   = n_ctx[q_lat];
      a_cur   = a_ctx[q_lat];
      b_cur   = b_ctx[q_lat];
      at      = {2'd0, a_cur} + (q_lat ? {13'd0, n_cur[6:1]} : 19'd0);
      k_calc  = 4'd0;
      for (int ii = 0; ii < 13; ii++) begin
         if (({12'd0, n_cur} << ii) < at)
            k_calc = k_calc + 4'd1;
      end
      lm_calc = 5'(LIMIT) - {1'b0, cn_lat};

      // Regular code: zc is the high part, k raw bits the low part; escape carries merr-1 in 8 bits.
      kmask   = (10'd1 << o_k) - 10'd1;
      zc_sh   = {5'd0, zc_lat} << o_k;
      merr    = (zc_lat < o_lm) ? (zc_sh | ({2'd0, bv_lat} & kmask))
                                : ({2'd0, bv_lat} + 10'd1);
      map     = merr[0] ^ q_lat;
      abserr  = 10'(({1'b0, merr} + 11'(q_lat) + 11'(map)) >> 1);
      cond    = (o_k == 4'd0) && ({b_cur, 1'b0} < {1'b0, n_cur});
      err_pos = (abserr != 10'd0) && (map ? cond : !cond);
      err_neg = (abserr != 10'd0) && !err_pos;
      add     = ~(s_lat ^ err_neg);
      x_calc  = add ? (px_lat + abserr[7:0]) : (px_lat - abserr[7:0]);

      halve   = (n_cur >= 7'd64);
      n_new   = halve ? ({1'b0, n_cur[6:1]} + 7'd1) : (n_cur + 7'd1);
      b_inc   = b_cur + {6'd0, err_neg};
      b_new   = halve ? {1'b0, b_inc[6:1]} : b_inc;
      a_inc   = a_cur + 17'(({1'b0, merr} + 11'(!q_lat)) >> 1);
      a_new   = halve ? {1'b0, a_inc[16:1]} : a_inc;
   end

`ifdef RUN_DEC_CHK_EN
   logic viol;
   assign viol = (zc_lat > o_lm) || (abserr > 10'd128) || (err_pos && (abserr == 10'd128));
`else
   assign o_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         o_vl     <= 1'b0;
         o_kvl    <= 1'b0;
         o_x      <= 8'd0;
         o_k      <= 4'd0;
         o_lm     <= 5'd0;
         px_lat   <= 8'd0;
         s_lat    <= 1'b0;
         q_lat    <= 1'b0;
         cn_lat   <= 4'd0;
         zc_lat   <= 5'd0;
         bv_lat   <= 8'd0;
         n_ctx[0] <= N_INIT;
         n_ctx[1] <= N_INIT;
         a_ctx[0] <= A_INIT;
         a_ctx[1] <= A_INIT;
         b_ctx[0] <= B_INIT;
         b_ctx[1] <= B_INIT;
`ifdef RUN_DEC_CHK_EN
         o_err    <= 1'b0;
`endif
      end else if (i_init) begin
         state    <= S_IDLE;
         o_vl     <= 1'b0;
         o_kvl    <= 1'b0;
         n_ctx[0] <= N_INIT;
         n_ctx[1] <= N_INIT;
         a_ctx[0] <= A_INIT;
         a_ctx[1] <= A_INIT;
         b_ctx[0] <= B_INIT;
         b_ctx[1] <= B_INIT;
`ifdef RUN_DEC_CHK_EN
         o_err    <= 1'b0;
`endif
      end else begin
         o_vl <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (i_vl) begin
                  px_lat <= i_px;
                  s_lat  <= i_s;
                  q_lat  <= i_q;
                  cn_lat <= i_cn;
                  state  <= S_KCAL;
               end
            end
            S_KCAL: begin
               o_k   <= k_calc;
               o_lm  <= lm_calc;
               o_kvl <= 1'b1;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (i_bvl) begin
                  zc_lat <= i_zc;
                  bv_lat <= i_bv;
                  o_kvl  <= 1'b0;
                  state  <= S_REC;
               end
            end
            S_REC: begin
               o_x          <= x_calc;
               o_vl         <= 1'b1;
               n_ctx[q_lat] <= n_new;
               a_ctx[q_lat] <= a_new;
               b_ctx[q_lat] <= b_new;
`ifdef RUN_DEC_CHK_EN
               if (viol)
                  o_err <= 1'b1;
`endif
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_run_dec.sv
// ============================================================================
// tb_run_dec: self-checking bench for run_dec with a context model and result scoreboard. Rev 1.0
// ============================================================================
`default_nettype none

module tb_run_dec;

   logic       clk = 1'b0;
   logic       rstn;
   logic       i_init;
   logic       i_vl;
   logic       o_rdy;
   logic [7:0] i_px;
   logic       i_s;
   logic       i_q;
   logic [3:0] i_cn;
   logic       o_kvl;
   logic [3:0] o_k;
   logic [4:0] o_lm;
   logic       i_bvl;
   logic [4:0] i_zc;
   logic [7:0] i_bv;
   logic       o_vl;
   logic [7:0] o_x;
   logic       o_err;

   always #5 clk = ~clk;

   run_dec #(.LIMIT(23)) dut (
      .clk(clk), .rstn(rstn), .i_init(i_init), .i_vl(i_vl), .o_rdy(o_rdy),
      .i_px(i_px), .i_s(i_s), .i_q(i_q), .i_cn(i_cn),
      .o_kvl(o_kvl), .o_k(o_k), .o_lm(o_lm),
      .i_bvl(i_bvl), .i_zc(i_zc), .i_bv(i_bv),
      .o_vl(o_vl), .o_x(o_x), .o_err(o_err)
   );

   int compared   = 0;
   int mismatched = 0;

   // reference context and current-sample state
   int mN [2];
   int mA [2];
   int mB [2];
   int m_err_flag;
   int cur_px, cur_s, cur_q, cur_k, cur_lm;
   int exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mN[i] = 1;
         mA[i] = 4;
         mB[i] = 0;
      end
      m_err_flag = 0;
   endtask

   function automatic int model_k(input int q);
      int at_v, kk;
      at_v = mA[q] + (q != 0 ? mN[q] / 2 : 0);
      kk = 0;
      for (int ii = 0; ii <= 12; ii++)
         if ((mN[q] * (1 << ii)) < at_v) kk++;
      return kk;
   endfunction

   function automatic int exp_err_out();
`ifdef RUN_DEC_CHK_EN
      return m_err_flag;
`else
      return 0;
`endif
   endfunction

   task automatic model_rec(input int zc, input int bv, output int x);
      int merr, mp, ab, err, nold, q;
      bit cnd, pos;
      q = cur_q;
      if (zc < cur_lm) merr = (zc * (1 << cur_k)) + (bv % (1 << cur_k));
      else             merr = bv + 1;
      mp  = (merr + q) % 2;
      ab  = (merr + q + mp) / 2;
      cnd = (cur_k == 0) && (2 * mB[q] < mN[q]);
      pos = (mp != 0) ? cnd : !cnd;
      if (ab == 0)  err = 0;
      else if (pos) err = ab;
      else          err = -ab;
      x = (cur_s != 0) ? (cur_px - err) : (cur_px + err);
      x = ((x % 256) + 256) % 256;
      if (zc > cur_lm || ab > 128 || err == 128) m_err_flag = 1;
      nold = mN[q];
      mB[q] = mB[q] + (err < 0 ? 1 : 0);
      mA[q] = mA[q] + (merr + (q == 0 ? 1 : 0)) / 2;
      if (nold >= 64) begin
         mN[q] = nold / 2 + 1;
         mB[q] = mB[q] / 2;
         mA[q] = mA[q] / 2;
      end else begin
         mN[q] = nold + 1;
      end
   endtask

   task automatic request(input int px, input int s, input int q, input int cn, input string tag);
      int n;
      @(negedge clk);
      chk({tag, "_rdy"}, 32'(o_rdy), 32'd1);
      i_vl = 1'b1; i_px = 8'(px); i_s = 1'(s); i_q = 1'(q); i_cn = 4'(cn);
      cur_px = px; cur_s = s; cur_q = q;
      @(negedge clk);
      i_vl = 1'b0;
      n = 0;
      while (!o_kvl && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_kvl"}, 32'(o_kvl), 32'd1);
      chk({tag, "_klat"}, 32'(n), 32'd1);
      cur_k  = model_k(q);
      cur_lm = 23 - cn;
      chk({tag, "_k"}, 32'(o_k), 32'(cur_k));
      chk({tag, "_lm"}, 32'(o_lm), 32'(cur_lm));
   endtask

   task automatic respond(input int zc, input int bv, input string tag);
      int n, x;
      @(negedge clk);
      i_bvl = 1'b1; i_zc = 5'(zc); i_bv = 8'(bv);
      model_rec(zc, bv, x);
      exp_q.push_back(x);
      @(negedge clk);
      i_bvl = 1'b0;
      n = 0;
      while (!o_vl && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_vl"}, 32'(o_vl), 32'd1);
      chk({tag, "_vlat"}, 32'(n), 32'd1);
      chk({tag, "_rdy_vl"}, 32'(o_rdy), 32'd1);
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk({tag, "_x"}, 32'(o_x), 32'(x));
      end
      chk({tag, "_err"}, 32'(o_err), 32'(exp_err_out()));
   endtask

   task automatic run_sample(input int px, input int s, input int q, input int cn,
                             input int zc, input int bv, input string tag);
      request(px, s, q, cn, tag);
      respond(zc, bv, tag);
   endtask

   task automatic pulse_init();
      @(negedge clk);
      i_init = 1'b1;
      @(negedge clk);
      i_init = 1'b0;
      model_reset();
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen_vl, kvl_drop;
      rstn = 1'b0; i_init = 1'b0; i_vl = 1'b0; i_px = 8'd0; i_s = 1'b0; i_q = 1'b0;
      i_cn = 4'd0; i_bvl = 1'b0; i_zc = 5'd0; i_bv = 8'd0;
      model_reset();
      #12;
      chk("rst_vl",  32'(o_vl),  32'd0);
      chk("rst_kvl", 32'(o_kvl), 32'd0);
      chk("rst_x",   32'(o_x),   32'd0);
      chk("rst_k",   32'(o_k),   32'd0);
      chk("rst_lm",  32'(o_lm),  32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_rdy", 32'(o_rdy), 32'd1);
      @(negedge clk);
      rstn = 1'b1;

      // directed reference points
      request(7, 0, 0, 0, "t1");
      chk("t1_k_const", 32'(o_k), 32'd2);
      chk("t1_lm_const", 32'(o_lm), 32'd23);
      respond(1, 2, "t1");
      chk("t1_x_const", 32'(o_x), 32'd10);
      run_sample(100, 1, 0, 0, 0, 1, "t2");
      chk("t2_x_const", 32'(o_x), 32'd101);

      @(negedge clk); rstn = 1'b0; model_reset(); exp_q.delete();
      @(negedge clk); rstn = 1'b1;
      run_sample(8'h40, 0, 0, 0, 23, 8'hFE, "t3");
      chk("t3_x_const", 32'(o_x), 32'hC0);

      // code violation: err = +128 through escape
      run_sample(8'h10, 0, 0, 0, 23, 8'hFF, "t4a");
      run_sample(8'h33, 0, 0, 5, 0, 1, "t4b");
      pulse_init();
      chk("t4_err_clr", 32'(o_err), 32'd0);
      run_sample(8'h40, 0, 0, 0, 23, 8'hFE, "t4c");
      chk("t4c_x_const", 32'(o_x), 32'hC0);

      // parser stall with a stray request in WAIT
      request(50, 0, 1, 3, "t5");
      seen_vl = 1'b0; kvl_drop = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         i_vl = (c >= 5 && c < 10);
         i_px = 8'd200;
         if (o_vl) seen_vl = 1'b1;
         if (!o_kvl || o_rdy) kvl_drop = 1'b1;
      end
      i_vl = 1'b0;
      chk("t5_kvl_held", 32'(kvl_drop), 32'd0);
      chk("t5_no_vl", 32'(seen_vl), 32'd0);
      chk("t5_rdy", 32'(o_rdy), 32'd0);
      respond(2, 5, "t5");

      // i_init aborts an in-flight sample
      request(9, 0, 0, 1, "t5i");
      pulse_init();
      chk("t5i_kvl", 32'(o_kvl), 32'd0);
      chk("t5i_rdy", 32'(o_rdy), 32'd1);

      // long q=1 run through the N halving point
      for (int i = 0; i < 65; i++) begin
         run_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 1,
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 255)), $sformatf("t6_%0d", i));
      end

      // async reset in WAIT
      request(77, 0, 1, 2, "t6r");
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("t6r_kvl", 32'(o_kvl), 32'd0);
      chk("t6r_rdy", 32'(o_rdy), 32'd1);
      chk("t6r_err", 32'(o_err), 32'd0);
      model_reset(); exp_q.delete();
      @(negedge clk); rstn = 1'b1;
      request(7, 0, 1, 0, "t6s");
      chk("t6s_k_const", 32'(o_k), 32'd2);
      respond(1, 2, "t6s");
      run_sample(7, 0, 0, 0, 1, 2, "t6t");
      chk("t6t_x_const", 32'(o_x), 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
